pipelined_adder: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out and signed overflow.

---
 rtl/pipelined_adder_pkg.sv | 11 +
 rtl/pipelined_adder_chunk.sv | 29 ++
 rtl/pipelined_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared sizing defaults and helpers for the pipelined adder/subtractor.
package pipelined_adder_pkg;

    localparam int ADD_WIDTH_DEFAULT = 16;
    localparam int ADD_CHUNK_DEFAULT = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry segment built from full-adder cells.
// c_msb_in is the carry entering the top bit, needed for signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Skewed-pipeline adder/subtractor: one CHUNK-bit ripple segment per stage,
// inter-segment carry registered, one result per cycle.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT,
    parameter int CHUNK = ADD_CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    // Handshake: a beat moves on an edge where valid & ready are both high.
    // The whole pipe shifts together when the last stage is empty or drained,
    // so in_ready is simply that advance condition.
    logic                             advance;
    logic [WIDTH-1:0]                 b_eff;
    logic [STAGES-1:0]                v_q, v_d, c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                             ovf_q, ovf_d;
    logic [STAGES-1:0][CHUNK-1:0]     ch_a, ch_b, ch_sum;
    logic [STAGES-1:0]                ch_cin, ch_cout, ch_cmsb;
    logic                             unused_bits;

    assign b_eff    = in_sub ? ~in_b : in_b;
    assign advance  = !v_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ch_a[k]   = in_a[CHUNK-1:0];
            assign ch_b[k]   = b_eff[CHUNK-1:0];
            assign ch_cin[k] = in_cin ^ in_sub;
        end else begin : g_rest
            assign ch_a[k]   = a_q[k-1][k*CHUNK +: CHUNK];
            assign ch_b[k]   = b_q[k-1][k*CHUNK +: CHUNK];
            assign ch_cin[k] = c_q[k-1];
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (ch_a[k]),
            .b        (ch_b[k]),
            .cin      (ch_cin[k]),
            .sum      (ch_sum[k]),
            .cout     (ch_cout[k]),
            .c_msb_in (ch_cmsb[k])
        );
    end

    always_comb begin
        v_d   = v_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        if (advance) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                a_d[0]               = in_a;
                b_d[0]               = b_eff;
                sum_d[0]             = '0;
                sum_d[0][CHUNK-1:0]  = ch_sum[0];
                c_d[0]               = ch_cout[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    a_d[k]                     = a_q[k-1];
                    b_d[k]                     = b_q[k-1];
                    sum_d[k]                   = sum_q[k-1];
                    sum_d[k][k*CHUNK +: CHUNK] = ch_sum[k];
                    c_d[k]                     = ch_cout[k];
                end
            end
            // Overflow is only meaningful for the segment holding the MSB.
            if (v_d[STAGES-1]) begin
                ovf_d = ch_cout[STAGES-1] ^ ch_cmsb[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;

    // Already-consumed operand bits and lower-stage MSB carries are not needed.
    assign unused_bits = ^{a_q, b_q, ch_cmsb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors and corner sequences on 16/4,
// random traffic on 16/16 and 8/2 against an arithmetic reference model.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst, in_valid, in_ready, in_sub, in_cin;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [15:0] in_a, in_b, out_sum;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Signed/unsigned integer arithmetic; returns {ovf, cout, sum[15:0]}.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic cin);
        longint md, half, ua, ub, sa, sb, ci, r, u, s;
        logic   co, ov;
        md   = longint'(1) << w;
        half = md / 2;
        ua   = longint'(a) & (md - 1);
        ub   = longint'(b) & (md - 1);
        sa   = (ua >= half) ? ua - md : ua;
        sb   = (ub >= half) ? ub - md : ub;
        ci   = cin ? longint'(1) : longint'(0);
        if (sub) begin
            r  = sa - sb - ci;
            u  = ua - ub - ci;
            co = (u >= 0);
        end else begin
            r  = sa + sb + ci;
            u  = ua + ub + ci;
            co = (u >= md);
        end
        ov = (r < -half) || (r >= half);
        s  = ((u % md) + md) % md;
        return {ov, co, 16'(s)};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    // Called just after a clock edge with the pipe empty.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                            output int lat, output logic [15:0] sum, output logic co, output logic ov);
        in_a = a; in_b = b; in_sub = s; in_cin = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        lat  = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum; co = out_cout; ov = out_ovf;
        @(posedge clk); #1;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
        localparam int RW   = (gi == 0) ? 16 : 8;
        localparam int RC   = (gi == 0) ? 16 : 2;
        localparam int RLAT = RW / RC;

        logic          r_rst, r_iv, r_ir, r_sub, r_cin, r_ov, r_or, r_co, r_of;
        logic [RW-1:0] r_a, r_b, r_sum;
        logic          done = 1'b0;
        logic [17:0]   exp_q[$];

        pipelined_adder #(.WIDTH(RW), .CHUNK(RC)) u_dut (
            .clk       (clk),
            .reset     (r_rst),
            .in_valid  (r_iv),
            .in_ready  (r_ir),
            .in_a      (r_a),
            .in_b      (r_b),
            .in_sub    (r_sub),
            .in_cin    (r_cin),
            .out_valid (r_ov),
            .out_ready (r_or),
            .out_sum   (r_sum),
            .out_cout  (r_co),
            .out_ovf   (r_of)
        );

        initial begin
            int          acc;
            int          lat;
            logic [17:0] want;
            r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b1;
            r_a = '0; r_b = '0; r_sub = 1'b0; r_cin = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            r_rst = 1'b0;

            r_a = RW'(5); r_b = RW'(3); r_iv = 1'b1;
            @(posedge clk); #1;
            r_iv = 1'b0;
            lat  = 1;
            while (!r_ov && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("rnd%0d_latency", gi), lat, RLAT);
            chk($sformatf("rnd%0d_lat_sum", gi), 32'(r_sum), 32'd8);
            @(posedge clk); #1;

            acc = 0;
            for (int cyc = 0; cyc < 8000 && (acc < 1000 || exp_q.size() != 0); cyc++) begin
                r_iv  = (acc < 1000) && ($urandom_range(0, 3) != 0);
                r_a   = RW'($urandom);
                r_b   = RW'($urandom);
                r_sub = 1'($urandom_range(0, 1));
                r_cin = 1'($urandom_range(0, 1));
                r_or  = ($urandom_range(0, 3) != 0);
                #1;
                if (r_ov && r_or) begin
                    want = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
                    chk($sformatf("rnd%0d_beat", gi), {14'd0, r_of, r_co, 16'(r_sum)}, {14'd0, want});
                end
                if (r_iv && r_ir) begin
                    exp_q.push_back(ref_add(RW, 16'(r_a), 16'(r_b), r_sub, r_cin));
                    acc++;
                end
                @(posedge clk); #1;
            end
            chk($sformatf("rnd%0d_accepted", gi), acc, 1000);
            chk($sformatf("rnd%0d_drained", gi), exp_q.size(), 0);
            r_iv = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int          lat, got, sent, stall_cycles, emerged;
        logic [15:0] sum;
        logic        co, ov, prev_stall;
        logic [18:0] prev_out;
        logic [15:0] sa[8], sb[8];
        logic        ss[8], sc[8];
        logic [17:0] exp_q[$];

        vecs[0] = '{16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", {out_ovf, out_cout, out_sum}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat, sum, co, ov);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), co, vecs[i].cout);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
        end

        // Back-to-back stream with a 3-cycle consumer stall.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom);
            ss[i] = 1'($urandom_range(0, 1)); sc[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; stall_cycles = 0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_a = sa[sent]; in_b = sb[sent]; in_sub = ss[sent]; in_cin = sc[sent];
            end
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (prev_stall) begin
                chk("stall_hold", {out_valid, out_ovf, out_cout, out_sum}, prev_out);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                stall_cycles++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_ovf, out_cout, out_sum};
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", got), {out_ovf, out_cout, out_sum},
                    (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff);
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(16, in_a, in_b, in_sub, in_cin));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", got, 8);
        chk("stream_stall_cycles", stall_cycles, 3);
        chk("stream_leftover", exp_q.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        rst = 1'b0;
        emerged = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) emerged++;
        end
        chk("flush_none_emerge", emerged, 0);
        send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, sum, co, ov);
        chk("fresh_latency", lat, 4);
        chk("fresh_sum", {ov, co, sum}, {2'b00, 16'h0100});

        for (int i = 0; i < 20000 && !(g_rnd[0].done && g_rnd[1].done); i++) @(posedge clk);
        chk("rnd_done", {g_rnd[0].done, g_rnd[1].done}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
